// File: rtl/apb_master.sv
// apb_master: APB3 requester turning single-word commands into APB transfers.
// Runs IDLE -> SETUP -> ACCESS, honours PREADY/PSLVERR, aborts on wait timeout.
module apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic        accept;
  logic        done;
  logic        expire;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done || expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Completion has priority over a timeout landing on the same edge.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    accept    = cmd_valid && cmd_ready;
    done      = (state == ACCESS) && PSEL && PENABLE && PREADY;
    expire    = (state == ACCESS) && !PREADY &&
                (TO_LIM != 16'd0) &&
                ((wait_cnt + 16'd1) == TO_LIM);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= 16'd0;
    end else begin
      PSEL      <= (state_nxt != IDLE);
      PENABLE   <= (state_nxt == ACCESS);
      rsp_valid <= done || expire;
      if (accept) begin
        PWRITE   <= cmd_write;
        PADDR    <= cmd_addr;
        PWDATA   <= cmd_wdata;
        wait_cnt <= 16'd0;
      end else if (state == ACCESS && !PREADY) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (done) begin
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (expire) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB3 requester that turns single-word commands from an on-chip command port into APB transfers toward the peripheral register blocks. It runs the IDLE→SETUP→ACCESS protocol, honours PREADY wait states and PSLVERR, and bounds each transfer with a wait-state timeout. It returns one response per command, and sits between the control fabric and the peripheral APB bus.

## Interface
- ADDR_WIDTH, 32, width of cmd_addr and PADDR.
- DATA_WIDTH, 32, width of data paths.
- TIMEOUT, 255, maximum ACCESS cycles with PREADY low before abort (1..65535; 0 disables the timeout).
- PCLK  input  1  clock; all logic on rising edge.
- PRESETn  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a PCLK edge.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  target address.
- cmd_wdata  input  DATA_WIDTH  write data (ignored for reads).
- rsp_valid  output  1  one-cycle response pulse; no backpressure.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  output  1  PSLVERR seen, or timeout.
- rsp_timeout  output  1  transfer aborted by timeout.
- busy  output  1  high in SETUP and ACCESS.
- PSEL, PENABLE, PWRITE  output  1 each  APB controls.
- PADDR  output  ADDR_WIDTH; PWDATA  output  DATA_WIDTH.
- PRDATA  input  DATA_WIDTH; PREADY  input  1; PSLVERR  input  1.

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered except cmd_ready = (state == IDLE) and busy = (state != IDLE).
- IDLE: on accept, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP. Otherwise stay.
- SETUP: PSEL=1, PENABLE=0. Always goes to ACCESS next.
- ACCESS: PSEL=1, PENABLE=1.
  - At an edge with PREADY=1: capture PRDATA (reads only) into rsp_rdata, PSLVERR into rsp_err, rsp_timeout=0, assert rsp_valid, go to IDLE.
  - While PREADY=0: 16-bit wait counter increments. When the counter equals TIMEOUT (TIMEOUT≠0), abort: rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to IDLE.
  - PREADY=1 on the same edge as the timeout: normal completion wins.
- The wait counter clears on entry to SETUP.
- PSEL and PENABLE drop to 0 in the cycle after completion. PWRITE, PADDR and PWDATA hold their last values until the next accept.
- PADDR, PWRITE and PWDATA stay stable from SETUP through the end of ACCESS. Changes on cmd_* during a transfer are ignored.
- PSLVERR and PRDATA are sampled only when PSEL && PENABLE && PREADY.
- Reset (PRESETn low at an edge), including mid-transfer:
  - State goes to IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid, rsp_err and rsp_timeout go to 0.
  - PADDR, PWDATA and rsp_rdata go to 0; the wait counter clears.
  - An in-flight command is dropped with no response.

## Timing
- Edge 0: accept. Cycles 1–2: SETUP then ACCESS (zero-wait slave). Cycle 3: rsp_valid=1, state IDLE, cmd_ready=1.
- Minimum period is 3 cycles per command. Accept may occur in the same cycle rsp_valid is high.
- Each PREADY-low cycle adds one cycle of latency.
- Timeout: with TIMEOUT=N, rsp_valid rises after exactly N ACCESS cycles with PREADY low (cycle 2+N).
- rsp_valid is high for exactly one cycle per accepted command.
- Reset values: cmd_ready=1 from the first cycle after reset; every other output is 0.

## Test plan
- Zero-wait write: cmd addr=0x0, wdata=0xDEADBEEF, PREADY=1 → SETUP in cycle 1 with PADDR=0x0 and PWDATA=0xDEADBEEF; ACCESS in cycle 2; rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read with 3 wait states: PREADY low for 3 ACCESS cycles, then PRDATA=0x12345678 with PREADY=1 → rsp_valid in cycle 6 with rsp_rdata=0x12345678; PADDR stable throughout.
- Slave error: write with PSLVERR=1 and PREADY=1 → rsp_err=1, rsp_timeout=0; next command is accepted in the response cycle.
- Timeout: TIMEOUT=4, PREADY held low → rsp_valid in cycle 6 with rsp_err=1, rsp_timeout=1, rsp_rdata=0; PSEL=0 in cycle 7. Repeat with PREADY=1 on the 4th wait cycle → normal completion.
- Back-to-back: cmd_valid held high for 4 commands with a zero-wait slave → 4 responses on cycles 3, 6, 9 and 12, in order.
- Reset mid-ACCESS: PRESETn low for one edge during ACCESS with PREADY low → PSEL=PENABLE=0 next cycle, no rsp_valid, cmd_ready=1 after reset.
